// File: rtl/reg_ctx_mover_pkg.sv
// Shared types and constants for the register-context mover.
package reg_ctx_mover_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_REQ = 3'd1,
    RD_REQ   = 3'd2,
    RD_WB    = 3'd3,
    DONE     = 3'd4,
    CHK_REQ  = 3'd5,
    CHK_WB   = 3'd6
  } state_e;

  localparam int unsigned CTX_NUM_REGS = 32;
  localparam int unsigned REG_IDX_W    = 5;
  localparam int unsigned PC_SLOT      = 0;
  localparam int unsigned CHK_OFFSET   = CTX_NUM_REGS;

endpackage

// File: rtl/reg_ctx_mover_addr_gen.sv
// Slot counter for the context block: idx, base+idx (or base+CHK_OFFSET) and last-slot flag.
module ctx_addr_gen
  import reg_ctx_mover_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = CTX_NUM_REGS,
  parameter int unsigned IDX_W      = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clr_i,
  input  logic                  inc_i,
  input  logic                  chk_sel_i,
  input  logic [ADDR_WIDTH-1:0] base_i,
  output logic [IDX_W-1:0]      idx_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  last_o
);

  logic [IDX_W-1:0] idx_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q <= '0;
    end else if (clr_i) begin
      idx_q <= '0;
    end else if (inc_i) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Address arithmetic wraps naturally at 2^ADDR_WIDTH.
  assign addr_o = base_i + (chk_sel_i ? ADDR_WIDTH'(CHK_OFFSET) : ADDR_WIDTH'(idx_q));
  assign last_o = (idx_q == IDX_W'(NUM_REGS - 1));
  assign idx_o  = idx_q;

endmodule

// File: rtl/reg_ctx_mover.sv
// Moves one register bank to/from a memory context block (SAVE / RESTORE).
// Optional CTX_CHECKSUM_EN appends an XOR checksum word and a chk_err output.
module reg_ctx_mover
  import reg_ctx_mover_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_REGS   = CTX_NUM_REGS
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  cmd_save,
  input  logic                  bank_sel,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [DATA_WIDTH-1:0] proc_pc,
  output logic [REG_IDX_W-1:0]  rf_rd_addr,
  output logic                  rf_rd_bank,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  output logic                  rf_wr_en,
  output logic [REG_IDX_W-1:0]  rf_wr_addr,
  output logic                  rf_wr_bank,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] restored_pc
`ifdef CTX_CHECKSUM_EN
  ,
  output logic                  chk_err
`endif
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e                state_q;
  logic                  save_q;
  logic                  bank_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [DATA_WIDTH-1:0] pc_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] restored_pc_q;
`ifdef CTX_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] chk_q;
  logic                  chk_err_q;
`endif

  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic                  last_slot;
  logic                  accept;
  logic                  idx_clr;
  logic                  idx_inc;
  logic                  pc_slot;
  logic [DATA_WIDTH-1:0] save_word;

  assign accept    = (state_q == IDLE) && start;
  assign idx_clr   = accept || (state_q == DONE);
  assign idx_inc   = ((state_q == SAVE_REQ && mem_ack) || state_q == RD_WB) && !last_slot;
  assign pc_slot   = (idx == IDX_W'(PC_SLOT));
  assign save_word = pc_slot ? pc_q : rf_rd_data;

  ctx_addr_gen #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IDX_W      (IDX_W)
  ) u_addr_gen (
    .clk       (clk),
    .reset_n   (reset_n),
    .clr_i     (idx_clr),
    .inc_i     (idx_inc),
    .chk_sel_i (state_q == CHK_REQ),
    .base_i    (base_q),
    .idx_o     (idx),
    .addr_o    (slot_addr),
    .last_o    (last_slot)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      save_q        <= 1'b0;
      bank_q        <= 1'b0;
      base_q        <= '0;
      pc_q          <= '0;
      rdata_q       <= '0;
      restored_pc_q <= '0;
`ifdef CTX_CHECKSUM_EN
      chk_q         <= '0;
      chk_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            save_q  <= cmd_save;
            bank_q  <= bank_sel;
            base_q  <= base_addr;
            pc_q    <= proc_pc;
            state_q <= cmd_save ? SAVE_REQ : RD_REQ;
`ifdef CTX_CHECKSUM_EN
            chk_q     <= '0;
            chk_err_q <= 1'b0;
`endif
          end
        end
        SAVE_REQ: begin
          if (mem_ack) begin
`ifdef CTX_CHECKSUM_EN
            chk_q <= chk_q ^ save_word;
            if (last_slot) state_q <= CHK_REQ;
`else
            if (last_slot) state_q <= DONE;
`endif
          end
        end
        RD_REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state_q <= RD_WB;
          end
        end
        RD_WB: begin
          if (pc_slot) restored_pc_q <= rdata_q;
`ifdef CTX_CHECKSUM_EN
          chk_q   <= chk_q ^ rdata_q;
          state_q <= last_slot ? CHK_REQ : RD_REQ;
`else
          state_q <= last_slot ? DONE : RD_REQ;
`endif
        end
`ifdef CTX_CHECKSUM_EN
        CHK_REQ: begin
          if (mem_ack) begin
            rdata_q <= mem_rdata;
            state_q <= save_q ? DONE : CHK_WB;
          end
        end
        CHK_WB: begin
          chk_err_q <= (rdata_q != chk_q);
          state_q   <= DONE;
        end
`endif
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    rf_rd_addr = '0;
    rf_rd_bank = 1'b0;
    rf_wr_en   = 1'b0;
    rf_wr_addr = '0;
    rf_wr_bank = 1'b0;
    rf_wr_data = '0;
    case (state_q)
      SAVE_REQ: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = slot_addr;
        mem_wdata  = save_word;
        rf_rd_addr = REG_IDX_W'(idx);
        rf_rd_bank = bank_q;
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = slot_addr;
      end
      RD_WB: begin
        if (!pc_slot) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = REG_IDX_W'(idx);
          rf_wr_bank = bank_q;
          rf_wr_data = rdata_q;
        end
      end
      CHK_REQ: begin
        mem_req  = 1'b1;
        mem_we   = save_q;
        mem_addr = slot_addr;
`ifdef CTX_CHECKSUM_EN
        mem_wdata = save_q ? chk_q : '0;
`endif
      end
      default: ;
    endcase
  end

  assign busy        = (state_q != IDLE) && (state_q != DONE);
  assign done        = (state_q == DONE);
  assign restored_pc = restored_pc_q;
`ifdef CTX_CHECKSUM_EN
  assign chk_err     = chk_err_q;
`endif

endmodule

// File: tb/tb_reg_ctx_mover.sv
// Bench for reg_ctx_mover: register-file and memory models, transaction scoreboard, command table.
module tb_reg_ctx_mover;

`ifdef CTX_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct {
    bit          save;
    bit          bank;
    logic [31:0] base;
    logic [31:0] pc;
    int          waits;
    int          poke;
    bit          exp_chk;
    int          exp_lat;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        cmd_save;
  logic        bank_sel;
  logic [31:0] base_addr;
  logic [31:0] proc_pc;
  logic [4:0]  rf_rd_addr;
  logic        rf_rd_bank;
  logic [31:0] rf_rd_data;
  logic        rf_wr_en;
  logic [4:0]  rf_wr_addr;
  logic        rf_wr_bank;
  logic [31:0] rf_wr_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] restored_pc;
`ifdef CTX_CHECKSUM_EN
  logic        chk_err;
`endif

  reg_ctx_mover dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .cmd_save    (cmd_save),
    .bank_sel    (bank_sel),
    .base_addr   (base_addr),
    .proc_pc     (proc_pc),
    .rf_rd_addr  (rf_rd_addr),
    .rf_rd_bank  (rf_rd_bank),
    .rf_rd_data  (rf_rd_data),
    .rf_wr_en    (rf_wr_en),
    .rf_wr_addr  (rf_wr_addr),
    .rf_wr_bank  (rf_wr_bank),
    .rf_wr_data  (rf_wr_data),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .done        (done),
    .restored_pc (restored_pc)
`ifdef CTX_CHECKSUM_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0] rf [2][32];
  logic [31:0] mem [logic [31:0]];
  txn_t        sb [$];
  bit          sb_en = 1'b1;
  int          wait_cfg = 0;
  int          wcnt = 0;
  bit          stray_ack = 1'b0;
  logic [31:0] req_addr, req_wdata;
  int          cyc = 0;
  int          done_cnt = 0;
  int          done_cyc = 0;
  int          rf_wr_cnt = 0;
  bit          done_chk_err = 1'b0;
  logic [31:0] exp_rpc = 32'h0;
  vec_t        vecs [6];

  assign rf_rd_data = rf[rf_rd_bank][rf_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] sentinel(input int b);
    return 32'hDEAD_0000 + 32'(b);
  endfunction

  function automatic int save_lat(input int w);
    return 1 + (32 + CHK) * (w + 1);
  endfunction

  function automatic int rest_lat(input int w);
    return 1 + (32 + CHK) * (w + 2);
  endfunction

  // Memory responder, register-file write port and scoreboard, all evaluated mid-cycle.
  always @(negedge clk) begin
    if (rf_wr_en) begin
      rf[rf_wr_bank][rf_wr_addr] = rf_wr_data;
      rf_wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
`ifdef CTX_CHECKSUM_EN
      done_chk_err = chk_err;
`endif
    end
    if (!mem_req) begin
      mem_ack = stray_ack;
      wcnt    = 0;
    end else begin
      if (wcnt == 0) begin
        req_addr  = mem_addr;
        req_wdata = mem_wdata;
      end
      if (wcnt >= wait_cfg) begin
        mem_ack = 1'b1;
        wcnt    = 0;
        if (wait_cfg > 0) check("req_hold", {mem_addr, mem_wdata}, {req_addr, req_wdata});
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata     = mem_rd(mem_addr);
        if (sb_en) begin
          if (sb.size() == 0) begin
            check("sb_extra_txn", {32'h0, mem_addr}, 64'hFFFF_FFFF);
          end else begin
            txn_t e;
            e = sb.pop_front();
            check("sb_we", 64'(mem_we), 64'(e.we));
            check("sb_addr", 64'(mem_addr), 64'(e.addr));
            if (e.we) check("sb_wdata", 64'(mem_wdata), 64'(e.data));
          end
        end
      end else begin
        mem_ack = 1'b0;
        wcnt++;
      end
    end
  end

  task automatic run_cmd(input vec_t v, input string tag);
    logic [31:0] exp_reg [32];
    logic [31:0] x;
    int          d0, w0, sc;
    x = 32'h0;
    for (int k = 0; k < 32; k++) begin
      logic [31:0] a, d;
      a = v.base + 32'(k);
      if (v.save) begin
        d = (k == 0) ? v.pc : rf[v.bank][k];
        sb.push_back('{1'b1, a, d});
        x = x ^ d;
      end else begin
        sb.push_back('{1'b0, a, 32'h0});
        exp_reg[k] = mem_rd(a);
      end
    end
    if (CHK != 0) sb.push_back('{v.save, v.base + 32'd32, x});
    wait_cfg = v.waits;
    @(negedge clk);
    start     = 1'b1;
    cmd_save  = v.save;
    bank_sel  = v.bank;
    base_addr = v.base;
    proc_pc   = v.pc;
    sc        = cyc;
    d0        = done_cnt;
    w0        = rf_wr_cnt;
    @(negedge clk);
    start = 1'b0;
    if (v.poke > 0) begin
      repeat (v.poke) @(negedge clk);
      start     = 1'b1;
      cmd_save  = 1'b0;
      bank_sel  = ~v.bank;
      base_addr = 32'h0000_0999;
      @(negedge clk);
      start = 1'b0;
    end
    for (int i = 0; i < 2000 && done_cnt == d0; i++) @(posedge clk);
    if (done_cnt == d0) begin
      check({tag, "_timeout"}, 64'h0, 64'h1);
    end else begin
      check({tag, "_latency"}, 64'(done_cyc - sc), 64'(v.exp_lat));
      repeat (3) @(negedge clk);
      check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'h1);
      check({tag, "_sb_left"}, 64'(sb.size()), 64'h0);
      check({tag, "_busy_after"}, 64'(busy), 64'h0);
      if (CHK != 0) check({tag, "_chk_err"}, 64'(done_chk_err), 64'(v.exp_chk));
      if (v.save) begin
        check({tag, "_rf_wr_during_save"}, 64'(rf_wr_cnt - w0), 64'h0);
      end else begin
        int bad;
        bad = 0;
        for (int k = 1; k < 32; k++) if (rf[v.bank][k] !== exp_reg[k]) bad++;
        check({tag, "_regs_bad"}, 64'(bad), 64'h0);
        check({tag, "_reg0"}, 64'(rf[v.bank][0]), 64'(sentinel(v.bank)));
        exp_rpc = exp_reg[0];
      end
      check({tag, "_restored_pc"}, 64'(restored_pc), 64'(exp_rpc));
    end
    sb.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    cmd_save  = 1'b0;
    bank_sel  = 1'b0;
    base_addr = 32'h0;
    proc_pc   = 32'h0;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    for (int b = 0; b < 2; b++) begin
      rf[b][0] = sentinel(b);
      for (int k = 1; k < 32; k++) rf[b][k] = (b == 1) ? 32'(k * 3) : 32'(k + 32'h50);
    end
    begin
      logic [31:0] x;
      mem[32'h200] = 32'hABC;
      x = 32'hABC;
      for (int k = 1; k < 32; k++) begin
        mem[32'h200 + 32'(k)] = 32'hF00 + 32'(k);
        x = x ^ (32'hF00 + 32'(k));
      end
      mem[32'h220] = x;
    end

    vecs[0] = '{1'b1, 1'b1, 32'h0000_0100, 32'h400,  0, 0,  1'b0, save_lat(0)};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_0200, 32'h0,    0, 0,  1'b0, rest_lat(0)};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_0300, 32'h400,  3, 0,  1'b0, save_lat(3)};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0380, 32'h777,  0, 10, 1'b0, save_lat(0)};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFF0, 32'h1234, 0, 0,  1'b0, save_lat(0)};
    vecs[5] = '{1'b0, 1'b1, 32'hFFFF_FFF0, 32'h0,    1, 0,  1'b0, rest_lat(1)};

    repeat (3) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_done", 64'(done), 64'h0);
    check("rst_rf_wr_en", 64'(rf_wr_en), 64'h0);
    check("rst_mem_addr", 64'(mem_addr), 64'h0);
    check("rst_restored_pc", 64'(restored_pc), 64'h0);
`ifdef CTX_CHECKSUM_EN
    check("rst_chk_err", 64'(chk_err), 64'h0);
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_cmd(vecs[i], $sformatf("vec%0d", i));

    begin
      int bad;
      bad = 0;
      for (int k = 0; k < 32; k++) if (mem_rd(32'h300 + 32'(k)) !== mem_rd(32'h100 + 32'(k))) bad++;
      check("wait_state_image_diff", 64'(bad), 64'h0);
    end

    // Acknowledge with no request outstanding: must not start anything.
    @(negedge clk);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    @(posedge clk);
    #1;
    check("stray_ack_busy", 64'(busy), 64'h0);
    check("stray_ack_mem_req", 64'(mem_req), 64'h0);

    // Reset in the middle of a RESTORE, at slot 10.
    begin
      bit hit;
      hit   = 1'b0;
      sb_en = 1'b0;
      wait_cfg = 0;
      @(negedge clk);
      start     = 1'b1;
      cmd_save  = 1'b0;
      bank_sel  = 1'b0;
      base_addr = 32'h600;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 200 && !hit; i++) begin
        @(posedge clk);
        #1;
        if (mem_req && !mem_we && mem_addr == 32'h60A) hit = 1'b1;
      end
      check("rst_mid_reached_idx10", 64'(hit), 64'h1);
      @(negedge clk);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst_mid_mem_req", 64'(mem_req), 64'h0);
      check("rst_mid_busy", 64'(busy), 64'h0);
      check("rst_mid_rf_wr_en", 64'(rf_wr_en), 64'h0);
      check("rst_mid_restored_pc", 64'(restored_pc), 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      exp_rpc = 32'h0;
      sb.delete();
      sb_en = 1'b1;
      run_cmd('{1'b1, 1'b1, 32'h0000_0700, 32'h4321, 0, 0, 1'b0, save_lat(0)}, "post_rst_save");
    end

`ifdef CTX_CHECKSUM_EN
    run_cmd('{1'b1, 1'b1, 32'h0000_0500, 32'h55AA, 0, 0, 1'b0, save_lat(0)}, "chk_save");
    mem[32'h505] = mem[32'h505] ^ 32'h1;
    run_cmd('{1'b0, 1'b0, 32'h0000_0500, 32'h0, 0, 0, 1'b1, rest_lat(0)}, "chk_corrupt_rest");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
